// File: rtl/fb_pkg.sv
// ============================================================
// fb_pkg: shared frame-buffer types and geometry defaults
// Rev 1.0
// ============================================================
`default_nettype none

package fb_pkg;

  typedef logic [2:0][7:0] color;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FB_ADDR_W    = 19;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DONE  = 1'b1
  } fetch_state_t;

  // Linear address of the last visible pixel of an h x v image.
  function automatic logic [FB_ADDR_W-1:0] last_pixel_addr(input int h, input int v);
    return FB_ADDR_W'(h * v - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_scanout_reader_pixel_fifo.sv
// ============================================================
// pixel_fifo: synchronous prefetch FIFO with registered head
// Rev 1.0
// ============================================================
`default_nettype none

module pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_ptr_next;
  logic [WIDTH-1:0] w_head_next;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign o_head    = r_head;
  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // The head register looks one entry ahead; a push landing in the slot
  // that becomes the head must be forwarded from the write data.
  always_comb begin
    w_rd_ptr_next = w_do_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    if (w_do_push && (r_wr_ptr == w_rd_ptr_next)) begin
      w_head_next = i_data;
    end else begin
      w_head_next = r_mem[w_rd_ptr_next];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_head <= w_head_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fb_scanout_reader.sv
// ============================================================
// fb_scanout_reader: raster-order frame-buffer prefetch engine
// Rev 1.0
// ============================================================
`default_nettype none

module fb_scanout_reader
  import fb_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_en,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        mem_rd,
  output logic [18:0] mem_addr,
  input  logic [23:0] mem_rdata,
  output logic [23:0] ReadColor,
  output logic        underflow,
  output logic        frame_start
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = last_pixel_addr(H_ACTIVE, V_ACTIVE);

  fetch_state_t         r_state;
  fetch_state_t         w_state_next;
  logic                 r_mem_rd;
  logic                 w_rd_next;
  logic [FB_ADDR_W-1:0] r_addr;
  logic [FB_ADDR_W-1:0] w_addr_next;
  logic [RD_LAT-1:0]    r_vld;
  logic [RD_LAT-1:0]    w_vld_next;
  logic [TW-1:0]        w_inflight;
  logic [TW-1:0]        w_total_next;

  logic                 w_active;
  logic                 w_flush;
  logic                 w_pop;
  logic                 w_push;
  color                 w_head;
  logic [CW-1:0]        w_count;
  logic                 w_empty;
  logic                 w_full;

  color                 r_color;
  logic                 r_underflow;
  logic                 r_frame_start;

  assign w_active = (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
  assign w_flush  = pix_en && (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
  assign w_pop    = pix_en && w_active && !w_empty;
  assign w_push   = r_vld[RD_LAT-1];

  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_addr;
  assign ReadColor   = r_color;
  assign underflow   = r_underflow;
  assign frame_start = r_frame_start;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (mem_rdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + TW'(r_vld[i]);
    end
  end

  // Occupancy the next cycle will see: the read being issued now joins the
  // in-flight set, a push just moves an entry from in-flight to stored.
  assign w_total_next = TW'(w_count) + w_inflight + TW'(r_mem_rd) - TW'(w_pop);
  assign w_vld_next   = w_flush ? '0 : ((r_vld << 1) | RD_LAT'(r_mem_rd));

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_rd_next    = 1'b0;
    if (w_flush) begin
      w_state_next = ST_FETCH;
      w_addr_next  = '0;
      w_rd_next    = 1'b1;
    end else begin
      if (r_mem_rd) begin
        if (r_addr == LAST_ADDR) begin
          w_state_next = ST_DONE;
        end else begin
          w_addr_next = r_addr + 1'b1;
        end
      end
      w_rd_next = (w_state_next == ST_FETCH) && (w_total_next < TW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_FETCH;
      r_mem_rd <= 1'b0;
      r_addr   <= '0;
      r_vld    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_mem_rd <= w_rd_next;
      r_addr   <= w_addr_next;
      r_vld    <= w_vld_next;
      assert (!(w_push && w_full && !w_flush));
    end
  end

  // Display side: no bypass from a same-cycle push, so an empty FIFO at a
  // visible pixel is always reported as underflow.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_color       <= '0;
      r_underflow   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_flush;
      if (pix_en) begin
        if (w_active && !w_empty) begin
          r_color <= w_head;
        end else begin
          r_color <= '0;
        end
        if (w_active && w_empty) begin
          r_underflow <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fb_scanout_reader.md
# fb_scanout_reader

Read-side engine of the frame buffer: walks the stored image in raster order, issues read requests to the frame-buffer memory port, and buffers the returned pixels in a small prefetch FIFO. It sits between the frame-buffer memory and the VGA controller. Each active pixel strobe pops one color onto `ReadColor`, keeping display reads decoupled from the ray-tracer write path.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line.
- `V_ACTIVE`, default 480: visible lines per frame.
- `RD_LAT`, default 2: fixed memory read latency in `Clk` cycles (≥1).
- `FIFO_DEPTH`, default 8: prefetch entries (power of two, ≥ `RD_LAT`+2).
- `Clk`  in  1  system clock (50 MHz); the only clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `pix_en`  in  1  one-cycle pixel strobe, at most every other `Clk`, aligned with `DrawX`/`DrawY` updates.
- `DrawX`  in  10  current VGA column.
- `DrawY`  in  10  current VGA line.
- `mem_rd`  out  1  read request, one address per cycle.
- `mem_addr`  out  19  linear pixel address, y*`H_ACTIVE`+x.
- `mem_rdata`  in  24  color {B,G,R}, valid exactly `RD_LAT` cycles after the matching `mem_rd`.
- `ReadColor`  out  24  color to the DAC, {B,G,R}.
- `underflow`  out  1  sticky: a pop was attempted on an empty FIFO.
- `frame_start`  out  1  one-cycle pulse when a frame refetch begins.

## Operation
- Fetch FSM states:
  - FETCH: `mem_rd`=1 when `count + inflight < FIFO_DEPTH`. `mem_addr` increments by 1 per issued read. A read issued at address `H_ACTIVE`*`V_ACTIVE`-1 moves the FSM to DONE.
  - DONE: `mem_rd`=0, waiting for flush.
- Flush event: `pix_en`=1 with `DrawX`=0 and `DrawY`=`V_ACTIVE` (start of vertical blank). On a flush:
  - FIFO emptied, in-flight valid pipeline cleared, and any returns still in flight discarded.
  - `mem_addr` set to 0, FSM goes to FETCH, `frame_start` pulses.
  - A flush arriving mid-FETCH preempts it the same way.
- `inflight`: number of set bits in an `RD_LAT`-deep valid shift register. A bit is set by `mem_rd` and pushes `mem_rdata` into the FIFO when it exits the register.
- Pop: `pix_en`=1 with `DrawX`<`H_ACTIVE` and `DrawY`<`V_ACTIVE`.
  - Non-empty FIFO: `ReadColor` takes the head entry.
  - Empty FIFO: `ReadColor`=0 and `underflow` is set. There is no bypass from a same-cycle push.
- `pix_en` outside the active area: `ReadColor`=0.
- Push and pop in the same cycle: count unchanged. Push into a full FIFO cannot occur by construction; treat it as an assertion failure.
- `underflow` clears only on `Reset`.

## Timing
- Reset values:
  - `mem_rd`=0, `mem_addr`=0, `ReadColor`=0, `underflow`=0, `frame_start`=0.
  - FIFO empty, valid pipeline cleared.
  - FSM=FETCH, so prefetch starts on the first cycle after `Reset` deasserts.
- `ReadColor` is registered and changes one `Clk` after the qualifying `pix_en`, then holds until the next `pix_en`.
- Memory returns take `RD_LAT` cycles from `mem_rd` to FIFO write, plus 1 cycle before the entry is poppable.
- Fill to `FIFO_DEPTH` after a flush takes ≤ `FIFO_DEPTH`+`RD_LAT`+1 cycles, well inside vertical blank.
- Throughput: 1 fetch per `Clk` against at most 1 pop per 2 `Clk`. Underflow occurs only if memory stalls, which is not modelled, or `pix_en` exceeds its spec.
- Reset asserted mid-frame: all state returns to reset values immediately. Prefetch restarts at address 0 and holds the first pixels until the next pops.

## Structure
- Shared package `fb_pkg` holds:
  - the `color` typedef (`logic [2:0][7:0]`);
  - `H_ACTIVE`/`V_ACTIVE` defaults;
  - the `FB_ADDR_W`=19 constant.
  The frame buffer and the write incrementer import it too.
- One sub-module, `pixel_fifo`:
  - synchronous FIFO with `push`/`pop`/`flush`, `count`, `empty`/`full`;
  - registered head output;
  - parameterised depth and width (24).
- The top of this block holds the FSM, the address counter, the valid shift register, and the pop/blank logic.

## Test plan
- Reset release with a memory model that returns data = address, `RD_LAT`=2: `mem_rd` is high for 8 cycles, then low. `mem_addr` runs 0..7 and the FIFO count reaches 8.
- Full frame with `pix_en` every 2 cycles, raster 800×525: `ReadColor` at pixel (x,y) equals y*640+x for every visible pixel, and is 0 in blanking. `underflow` stays 0.
- Last pixel: after the read at address 307199 the FSM is DONE and `mem_rd` stays 0 until `DrawY`=480, `DrawX`=0. Then `frame_start` pulses and `mem_addr` restarts at 0.
- Flush mid-fetch, forced at `DrawY`=480 with 2 reads in flight: those returns are discarded, and the first pixel popped in the next frame is address 0 (not stale data).
- Pops with memory returns suppressed for 20 cycles: once the FIFO drains, `ReadColor`=0 and `underflow` goes to 1 and stays 1 after the data resumes. `Reset` clears it.
- `Reset` asserted at pixel (100,50): all outputs are 0 on the same edge, and refetch starts at address 0 within 1 cycle of deassertion.
